regf_wb_queue: RTL

Writeback merge queue feeding the single write port of the integer register file. Accepts completed results from two producers (port A: in-order ALU pipeline; port B: long-latency unit such as mul/div or load return), buffers them in a small in-order FIFO, and retires one write per cycle on `regf_we` / `rd_s` / `rd_v`. It also exports a pending-write mask so issue logic can detect hazards against queued but not-yet-written results.

---
 rtl/regf_wb_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regf_wb_queue.sv
// regf_wb_queue: writeback merge queue in front of the single register-file
// write port. Two producers (A: ALU, B: long-latency unit) push completed
// results into an in-order circular buffer that drains one write per cycle.
// Optional build macro: WB_FWD_EN adds a combinational forward lookup port
// (fwd_rs_s / fwd_hit / fwd_v) returning the youngest queued value.
//
// Handshake: a producer transfers on any edge where its valid and ready are
// both high. Ready is derived from the registered occupancy only, so a
// same-cycle pop never grants extra room. B is ready only if there is room
// left after A's possible push this cycle. Results for x0 complete the
// handshake but are dropped.
module regf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_rd_s,
  input  logic [XLEN-1:0]            a_rd_v,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_rd_s,
  input  logic [XLEN-1:0]            b_rd_v,
  output logic                       regf_we,
  output logic [4:0]                 rd_s,
  output logic [XLEN-1:0]            rd_v,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                pending
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]                 fwd_rs_s,
  output logic                       fwd_hit,
  output logic [XLEN-1:0]            fwd_v
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

  logic [4:0]      mem_s [DEPTH];
  logic [XLEN-1:0] mem_v [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic a_push;
  logic b_push;
  logic pop;

  // Ready from registered occupancy; B must leave room for A's push.
  always_comb begin
    a_ready = (count < DEPTH_C);
    b_ready = a_valid ? (count < DEPTH_M1_C) : (count < DEPTH_C);
  end

  // Accepted handshakes that actually enqueue (x0 targets are dropped).
  always_comb begin
    a_push = a_valid && a_ready && (a_rd_s != 5'd0);
    b_push = b_valid && b_ready && (b_rd_s != 5'd0);
    pop    = (count != '0);
  end

  // Head entry drives the write port; all zero when empty.
  always_comb begin
    regf_we = pop;
    rd_s    = pop ? mem_s[head] : 5'd0;
    rd_v    = pop ? mem_v[head] : '0;
  end

  // Pointer and occupancy state; reset discards any queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(a_push) + PW'(b_push);
      count <= count + CW'(a_push) + CW'(b_push) - CW'(pop);
    end
  end

  // Entry storage: A lands in the tail slot, B right behind it (younger).
  always_ff @(posedge clk) begin
    if (a_push) begin
      mem_s[tail] <= a_rd_s;
      mem_v[tail] <= a_rd_v;
    end
    if (b_push) begin
      mem_s[tail + PW'(a_push)] <= b_rd_s;
      mem_v[tail + PW'(a_push)] <= b_rd_v;
    end
  end

  // Pending-write mask over occupied entries, head included.
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        pending[mem_s[head + PW'(k)]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

`ifdef WB_FWD_EN
  // Forward lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_v   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (fwd_rs_s != 5'd0) &&
          (mem_s[head + PW'(k)] == fwd_rs_s)) begin
        fwd_hit = 1'b1;
        fwd_v   = mem_v[head + PW'(k)];
      end
    end
  end
`endif

endmodule
